dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the CPU memory stage (port 0) and the SPU DMA/streaming engine (port 1). It sits between the requesters and the data memory port. It serialises accesses with round-robin priority and enforces the memory's one-extra-cycle read latency. Each requester gets a stall signal with the same semantics the CPU pipeline already uses: stall is high until the access completes.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `CNT_W`, default 16: width of the contention counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `p0_en`, `p1_en` in 1 each: access request, held until the port's stall is low.
- `p0_wr`, `p1_wr` in 1 each: 1 = write, 0 = read; valid with `en`.
- `p0_addr`, `p1_addr` in ADDR_W each: access address.
- `p0_wdata`, `p1_wdata` in DATA_W each: write data.
- `p0_rdata`, `p1_rdata` out DATA_W each: read data, valid in the completion cycle.
- `p0_stall`, `p1_stall` out 1 each: high while the port's request is pending and not completing this cycle.
- `data_mem_en`, `data_mem_wr` out 1 each: memory enable and write strobe.
- `data_mem_addr` out ADDR_W: memory address.
- `data_mem_write_data` out DATA_W: memory write data.
- `data_mem_data` in DATA_W: memory read data, valid one cycle after a read is issued.
- `conflict_cnt` out CNT_W: saturating count of cycles in which both ports requested.

## Operation
- **States:**
  - IDLE: no access outstanding.
  - RD: a read is outstanding; owner latched in `owner`.
- **IDLE, no request:**
  - `data_mem_en` = 0 and both stalls are 0.
- **IDLE, one or more requests:**
  - `rr_arb2` picks the winner.
  - The winner's `addr`, `wr` and `wdata` drive the memory with `data_mem_en` = 1.
  - Winner write: completes this cycle. Winner stall = 0, `last_grant` <= winner, stay in IDLE.
  - Winner read: winner stall = 1, `owner` <= winner, `last_grant` <= winner, go to RD.
  - Loser, if requesting: stall = 1.
- **RD:**
  - Memory is driven from the owner's held inputs with `en` = 1 and `wr` = 0.
  - Owner `rdata` = `data_mem_data` and owner stall = 0; the read completes this cycle.
  - Other port stalls if it is requesting.
  - Go to IDLE unconditionally.
- **Round-robin:**
  - When both ports request in IDLE, the port not equal to `last_grant` wins.
  - A single requester always wins.
- **rdata for a non-completing port:** `rdata` = `data_mem_data` as well; the value is don't-care and has no qualifier.
- **conflict_cnt:**
  - Increments in every cycle with `p0_en` & `p1_en`, in any state.
  - Saturates at all-ones.
- **Owner drops its request in RD (protocol violation):** the FSM still returns to IDLE and no error is flagged.

## Timing
- **Reset values:** state = IDLE, `last_grant` = 1 (port 0 wins the first conflict), `owner` = 0, `conflict_cnt` = 0.
- **During reset:** `data_mem_en` = 0, `data_mem_wr` = 0, both stalls = 0, `rdata` = `data_mem_data`.
- **Reset mid-read:** the access is abandoned. The next cycle is IDLE and the requester re-arbitrates.
- **Write latency:** 1 cycle with no stall when uncontended.
- **Read latency:** 2 cycles with exactly 1 stall cycle when uncontended.
- **Contended access:** the loser waits 1 cycle behind a write or 2 cycles behind a read.
- **Worst-case wait:** a continuously requesting port waits at most 2 cycles before being granted.
- **Back-to-back reads:** the port that completes in RD may be re-arbitrated in the next cycle (IDLE), subject to round-robin.
- **Memory port:** never enabled in two consecutive cycles for different owners during RD.

## Structure
- **Package `dmem_arb_pkg`:**
  - `arb_state_t` enum {IDLE, RD}.
  - Port ID constants P_CPU = 0 and P_SPU = 1.
  - Constant RD_LAT = 1.
- **Sub-module `rr_arb2`:**
  - Combinational two-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `gnt_valid`, `gnt_id`.
- **Top module:** FSM, output muxes and counter.

## Test plan
1. **Uncontended CPU read:**
   - Stimulus: `p0_en` = 1, `p0_wr` = 0, addr 0x100 at cycle 0; memory returns 0xDEADBEEF.
   - Required: `p0_stall` = 1 at cycle 0, 0 at cycle 1; `p0_rdata` = 0xDEADBEEF at cycle 1; `data_mem_addr` = 0x100 in both cycles.
2. **Uncontended SPU write:**
   - Stimulus: `p1` write, addr 0x40, data 0x55.
   - Required: in the same cycle `data_mem_en` = 1, `data_mem_wr` = 1, addr 0x40, data 0x55; `p1_stall` = 0.
3. **Simultaneous reads after reset:**
   - Stimulus: both ports issue reads.
   - Required: p0 is served in cycles 0–1 and p1 in cycles 2–3; `p1_stall` is high in cycles 0–2; `conflict_cnt` = 3 at the end.
4. **Round-robin alternation:**
   - Stimulus: both ports continuously write for 4 cycles.
   - Required: grants go p0, p1, p0, p1.
5. **Reset mid-read:**
   - Stimulus: `rst` asserted in RD.
   - Required: the next cycle is IDLE, `data_mem_en` = 0 during reset, `conflict_cnt` = 0, and the first conflict afterwards goes to p0.
6. **Counter saturation:**
   - Stimulus: set CNT_W = 4 and hold both requests for 20 cycles.
   - Required: `conflict_cnt` stops at 15.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RD   = 1'b1
   } arb_state_t;

   localparam logic P_CPU  = 1'b0;
   localparam logic P_SPU  = 1'b1;
   localparam int   RD_LAT = 1;

endpackage

// File: rtl/dmem_arb_if.sv
// rtl/dmem_arb_if.sv - requester and data-memory bundle between the two ports and the arbiter
interface dmem_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              p0_en;
   logic              p0_wr;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic [DATA_W-1:0] p0_rdata;
   logic              p0_stall;

   logic              p1_en;
   logic              p1_wr;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic [DATA_W-1:0] p1_rdata;
   logic              p1_stall;

   logic              data_mem_en;
   logic              data_mem_wr;
   logic [ADDR_W-1:0] data_mem_addr;
   logic [DATA_W-1:0] data_mem_write_data;
   logic [DATA_W-1:0] data_mem_data;

   modport slave (
      input  p0_en, p0_wr, p0_addr, p0_wdata,
      input  p1_en, p1_wr, p1_addr, p1_wdata,
      output p0_rdata, p0_stall, p1_rdata, p1_stall,
      output data_mem_en, data_mem_wr, data_mem_addr, data_mem_write_data,
      input  data_mem_data
   );

   modport master (
      output p0_en, p0_wr, p0_addr, p0_wdata,
      output p1_en, p1_wr, p1_addr, p1_wdata,
      input  p0_rdata, p0_stall, p1_rdata, p1_stall,
      input  data_mem_en, data_mem_wr, data_mem_addr, data_mem_write_data,
      output data_mem_data
   );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_id
);

   // Contention goes to the port that was not granted last; a lone requester always wins
   always_comb begin
      gnt_valid = |req;
      gnt_id    = P_CPU;
      if (req == 2'b11) begin
         gnt_id = ~last;
      end else if (req[1]) begin
         gnt_id = P_SPU;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of the single-port data memory between CPU and SPU
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   dmem_arb_if.slave        bus,
   output logic [CNT_W-1:0] conflict_cnt
);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic              owner_q;
   logic              owner_d;
   logic              last_q;
   logic              last_d;

   logic [1:0]        req;
   logic              gnt_valid;
   logic              gnt_id;
   logic              gnt_wr;
   logic              sel_id;
   logic              mem_en;
   logic              mem_wr;
   logic              stall0;
   logic              stall1;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign req = {bus.p1_en, bus.p0_en};

   rr_arb2 u_rr_arb2 (
      .req       (req),
      .last      (last_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   assign gnt_wr    = (gnt_id == P_SPU) ? bus.p1_wr    : bus.p0_wr;
   assign sel_addr  = (sel_id == P_SPU) ? bus.p1_addr  : bus.p0_addr;
   assign sel_wdata = (sel_id == P_SPU) ? bus.p1_wdata : bus.p0_wdata;

   assign bus.data_mem_en         = mem_en;
   assign bus.data_mem_wr         = mem_wr;
   assign bus.data_mem_addr       = sel_addr;
   assign bus.data_mem_write_data = sel_wdata;
   assign bus.p0_stall            = stall0;
   assign bus.p1_stall            = stall1;
   // Read data is broadcast unqualified; only the completing port's copy is meaningful
   assign bus.p0_rdata            = bus.data_mem_data;
   assign bus.p1_rdata            = bus.data_mem_data;

   // Next state, memory drive and stalls; everything idles while reset is held
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      sel_id  = P_CPU;
      mem_en  = 1'b0;
      mem_wr  = 1'b0;
      stall0  = 1'b0;
      stall1  = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (gnt_valid) begin
                  sel_id = gnt_id;
                  mem_en = 1'b1;
                  mem_wr = gnt_wr;
                  last_d = gnt_id;
                  // A write completes now; a read holds its owner for the data cycle
                  if (!gnt_wr) begin
                     state_d = RD;
                     owner_d = gnt_id;
                  end
                  if (gnt_id == P_SPU) begin
                     stall0 = bus.p0_en;
                     stall1 = ~gnt_wr;
                  end else begin
                     stall0 = ~gnt_wr;
                     stall1 = bus.p1_en;
                  end
               end
            end
            RD: begin
               // Keep re-presenting the owner's read while the memory returns its data
               sel_id  = owner_q;
               mem_en  = 1'b1;
               mem_wr  = 1'b0;
               stall0  = (owner_q == P_SPU) ? bus.p0_en : 1'b0;
               stall1  = (owner_q == P_SPU) ? 1'b0 : bus.p1_en;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, grant history and saturating contention counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= P_CPU;
         last_q       <= P_SPU;
         conflict_cnt <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         if (bus.p0_en && bus.p1_en && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } sb_entry_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] conflict_cnt;
   logic [3:0]  cnt4;

   int          n_cmp = 0;
   int          n_err = 0;
   logic        sb_on = 1'b1;
   sb_entry_t   sb_q0[$];
   sb_entry_t   sb_q1[$];
   int          grant_log[$];

   logic [31:0] mem [1024];
   logic [31:0] mem_rd_q = 32'h0;

   dmem_arb_if bus ();
   dmem_arb_if bus4 ();

   dmem_arbiter u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .conflict_cnt (conflict_cnt)
   );

   dmem_arbiter #(.CNT_W(4)) u_dut4 (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus4),
      .conflict_cnt (cnt4)
   );

   assign bus4.p0_en         = bus.p0_en;
   assign bus4.p0_wr         = bus.p0_wr;
   assign bus4.p0_addr       = bus.p0_addr;
   assign bus4.p0_wdata      = bus.p0_wdata;
   assign bus4.p1_en         = bus.p1_en;
   assign bus4.p1_wr         = bus.p1_wr;
   assign bus4.p1_addr       = bus.p1_addr;
   assign bus4.p1_wdata      = bus.p1_wdata;
   assign bus4.data_mem_data = bus.data_mem_data;
   assign bus.data_mem_data  = mem_rd_q;

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      return 32'hC0DE_0000 | {22'h0, a[9:0]};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Single-port memory model with one cycle of read latency
   always @(posedge clk) begin
      if (bus.data_mem_en) begin
         if (bus.data_mem_wr) mem[bus.data_mem_addr[9:0]] = bus.data_mem_write_data;
         else                 mem_rd_q <= mem[bus.data_mem_addr[9:0]];
      end
   end

   task automatic sb_check(input int pid, input logic [31:0] rdata);
      sb_entry_t e;
      int        qs;
      qs = (pid == 0) ? sb_q0.size() : sb_q1.size();
      if (qs == 0) begin
         check_eq($sformatf("p%0d_sb_pending", pid), 64'(qs), 64'd1);
      end else begin
         e = (pid == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
         grant_log.push_back(pid);
         check_eq($sformatf("p%0d_mem_wr", pid), 64'(bus.data_mem_wr), 64'(e.wr));
         check_eq($sformatf("p%0d_mem_addr", pid), 64'(bus.data_mem_addr), 64'(e.addr));
         if (e.wr) check_eq($sformatf("p%0d_wdata", pid), 64'(bus.data_mem_write_data), 64'(e.data));
         else      check_eq($sformatf("p%0d_rdata", pid), 64'(rdata), 64'(e.data));
      end
   endtask

   // Completion monitor: a requesting port that is not stalled is completing
   always @(negedge clk) begin
      if (!rst && sb_on) begin
         if (bus.p0_en && !bus.p0_stall) sb_check(0, bus.p0_rdata);
         if (bus.p1_en && !bus.p1_stall) sb_check(1, bus.p1_rdata);
      end
   end

   function automatic logic get_stall(input int pid);
      return (pid == 0) ? bus.p0_stall : bus.p1_stall;
   endfunction

   task automatic push_exp(input int pid, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      sb_entry_t e;
      e.wr   = wr;
      e.addr = addr;
      e.data = wr ? data : ref_word(addr);
      if (pid == 0) sb_q0.push_back(e);
      else          sb_q1.push_back(e);
   endtask

   task automatic drive_port(input int pid, input logic en, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      if (pid == 0) begin
         bus.p0_en = en; bus.p0_wr = wr; bus.p0_addr = addr; bus.p0_wdata = data;
      end else begin
         bus.p1_en = en; bus.p1_wr = wr; bus.p1_addr = addr; bus.p1_wdata = data;
      end
   endtask

   task automatic wait_done(input int pid);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         @(negedge clk);
         if (!get_stall(pid)) done = 1'b1;
      end
      check_eq($sformatf("p%0d_grant_wait", pid), 64'(done), 64'd1);
   endtask

   task automatic do_access(input int pid, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      drive_port(pid, 1'b1, wr, addr, data);
      push_exp(pid, wr, addr, data);
      wait_done(pid);
      @(posedge clk); #1;
      drive_port(pid, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [3:0] exp_s0;
      logic [3:0] exp_s1;
      int         exp_gnt [4];

      for (int i = 0; i < 1024; i++) mem[i] = ref_word(32'(i));
      mem[10'h100] = 32'hDEAD_BEEF;
      drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);

      // reset state with both ports requesting
      drive_port(0, 1'b1, 1'b0, 32'h8, 32'h0);
      drive_port(1, 1'b1, 1'b1, 32'hC, 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rst_mem_en", 64'(bus.data_mem_en), 64'd0);
      check_eq("rst_mem_wr", 64'(bus.data_mem_wr), 64'd0);
      check_eq("rst_p0_stall", 64'(bus.p0_stall), 64'd0);
      check_eq("rst_p1_stall", 64'(bus.p1_stall), 64'd0);
      check_eq("rst_cnt", 64'(conflict_cnt), 64'd0);
      check_eq("rst_p0_rdata", 64'(bus.p0_rdata), 64'(bus.data_mem_data));
      drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // uncontended CPU read
      drive_port(0, 1'b1, 1'b0, 32'h100, 32'h0);
      sb_q0.push_back('{wr: 1'b0, addr: 32'h100, data: 32'hDEAD_BEEF});
      @(negedge clk);
      check_eq("t1_stall_c0", 64'(bus.p0_stall), 64'd1);
      check_eq("t1_addr_c0", 64'(bus.data_mem_addr), 64'h100);
      check_eq("t1_en_c0", 64'(bus.data_mem_en), 64'd1);
      @(negedge clk);
      check_eq("t1_stall_c1", 64'(bus.p0_stall), 64'd0);
      check_eq("t1_addr_c1", 64'(bus.data_mem_addr), 64'h100);
      @(posedge clk); #1;
      drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);

      // uncontended SPU write
      drive_port(1, 1'b1, 1'b1, 32'h40, 32'h55);
      push_exp(1, 1'b1, 32'h40, 32'h55);
      @(negedge clk);
      check_eq("t2_mem_en", 64'(bus.data_mem_en), 64'd1);
      check_eq("t2_mem_wr", 64'(bus.data_mem_wr), 64'd1);
      check_eq("t2_addr", 64'(bus.data_mem_addr), 64'h40);
      check_eq("t2_wdata", 64'(bus.data_mem_write_data), 64'h55);
      check_eq("t2_stall", 64'(bus.p1_stall), 64'd0);
      @(posedge clk); #1;
      drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("t2_mem_word", 64'(mem[10'h40]), 64'h55);

      // simultaneous reads after reset; p0 keeps requesting a second read
      do_reset();
      exp_s0 = 4'b1101;
      exp_s1 = 4'b0111;
      fork
         begin
            do_access(0, 1'b0, 32'h10, 32'h0);
            do_access(0, 1'b0, 32'h14, 32'h0);
         end
         do_access(1, 1'b0, 32'h20, 32'h0);
         begin
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               check_eq($sformatf("t3_p0_stall_c%0d", k), 64'(bus.p0_stall), 64'(exp_s0[k]));
               check_eq($sformatf("t3_p1_stall_c%0d", k), 64'(bus.p1_stall), 64'(exp_s1[k]));
               if (k == 0) check_eq("t3_addr_c0", 64'(bus.data_mem_addr), 64'h10);
               if (k == 2) check_eq("t3_addr_c2", 64'(bus.data_mem_addr), 64'h20);
               if (k == 3) check_eq("t3_cnt_c3", 64'(conflict_cnt), 64'd3);
            end
         end
      join

      // round-robin alternation of continuous writes
      do_reset();
      grant_log.delete();
      fork
         begin
            do_access(0, 1'b1, 32'h200, 32'hA0A0_0001);
            do_access(0, 1'b1, 32'h204, 32'hA0A0_0002);
         end
         begin
            do_access(1, 1'b1, 32'h300, 32'hB0B0_0001);
            do_access(1, 1'b1, 32'h304, 32'hB0B0_0002);
         end
      join
      exp_gnt = '{0, 1, 0, 1};
      check_eq("t4_grants", 64'(grant_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check_eq($sformatf("t4_grant%0d", i), 64'(grant_log[i]), 64'(exp_gnt[i]));

      // reset mid-read: p0 alone takes RD, reset hits while p1 joins
      drive_port(0, 1'b1, 1'b0, 32'h30, 32'h0);
      @(negedge clk);
      check_eq("t5_stall_c0", 64'(bus.p0_stall), 64'd1);
      check_eq("t5_addr_c0", 64'(bus.data_mem_addr), 64'h30);
      @(posedge clk); #1;
      rst = 1'b1;
      drive_port(1, 1'b1, 1'b0, 32'h34, 32'h0);
      @(negedge clk);
      check_eq("t5_rst_en", 64'(bus.data_mem_en), 64'd0);
      check_eq("t5_rst_wr", 64'(bus.data_mem_wr), 64'd0);
      check_eq("t5_rst_p0_stall", 64'(bus.p0_stall), 64'd0);
      check_eq("t5_rst_p1_stall", 64'(bus.p1_stall), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      push_exp(0, 1'b0, 32'h30, 32'h0);
      push_exp(1, 1'b0, 32'h34, 32'h0);
      @(negedge clk);
      check_eq("t5_cnt", 64'(conflict_cnt), 64'd0);
      check_eq("t5_en_c2", 64'(bus.data_mem_en), 64'd1);
      check_eq("t5_addr_c2", 64'(bus.data_mem_addr), 64'h30);
      check_eq("t5_p0_stall_c2", 64'(bus.p0_stall), 64'd1);
      check_eq("t5_p1_stall_c2", 64'(bus.p1_stall), 64'd1);
      wait_done(0);
      @(posedge clk); #1;
      drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_done(1);
      @(posedge clk); #1;
      drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);

      // counter saturation with a 4-bit counter
      do_reset();
      sb_on = 1'b0;
      drive_port(0, 1'b1, 1'b1, 32'h3F0, 32'h1);
      drive_port(1, 1'b1, 1'b1, 32'h3F4, 32'h2);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_eq("t6_cnt4_mid", 64'(cnt4), 64'd10);
      check_eq("t6_cnt_mid", 64'(conflict_cnt), 64'd10);
      repeat (10) @(posedge clk);
      #1;
      drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check_eq("t6_cnt4_sat", 64'(cnt4), 64'd15);
      check_eq("t6_cnt_end", 64'(conflict_cnt), 64'd20);
      @(posedge clk); #1;
      sb_on = 1'b1;

      check_eq("sb_q0_drained", 64'(sb_q0.size()), 64'd0);
      check_eq("sb_q1_drained", 64'(sb_q1.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
